// File: rtl/mem_stage_pkg.sv
// Shared types and constants for the MEM pipeline stage: FSM encoding,
// data widths and the MEM/WB row layout.
package mem_stage_pkg;

    localparam int XLEN            = 32;
    localparam int REG_ADDR_W      = 5;
    localparam int DEFAULT_TIMEOUT = 255;
    localparam int WAIT_CNT_W      = 8;

    typedef enum logic {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } state_e;

    typedef struct packed {
        logic [XLEN-1:0]       read_data;
        logic [XLEN-1:0]       alu_result;
        logic [REG_ADDR_W-1:0] rd;
        logic                  regwrite;
        logic                  memtoreg;
    } mem_wb_t;

    localparam mem_wb_t MEM_WB_BUBBLE = '0;

endpackage

// File: rtl/mem_stage_if.sv
// Data-memory request/response bus between the MEM stage (master) and memory.
interface mem_stage_if;
    import mem_stage_pkg::*;

    logic            dmem_req;
    logic            dmem_we;
    logic [XLEN-1:0] dmem_addr;
    logic [XLEN-1:0] dmem_wdata;
    logic            dmem_ready;
    logic [XLEN-1:0] dmem_rdata;

    modport master (
        output dmem_req, dmem_we, dmem_addr, dmem_wdata,
        input  dmem_ready, dmem_rdata
    );

    modport slave (
        input  dmem_req, dmem_we, dmem_addr, dmem_wdata,
        output dmem_ready, dmem_rdata
    );

endinterface

// File: rtl/mem_stage_wb_reg.sv
// MEM/WB pipeline register; a bubble clears the whole row so writeback is suppressed.
module mem_wb_reg
    import mem_stage_pkg::*;
(
    input  logic    clk,
    input  logic    reset,
    input  logic    bubble,
    input  mem_wb_t row_d,
    output mem_wb_t row_q
);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            row_q <= MEM_WB_BUBBLE;
        end else if (bubble) begin
            row_q <= MEM_WB_BUBBLE;
        end else begin
            row_q <= row_d;
        end
    end

endmodule

// File: rtl/mem_stage.sv
// MEM stage: branch resolution, word-aligned data-memory access with a wait
// timeout, and the MEM/WB register.
//
// state  | meaning
// IDLE   | no bus activity; aligned load/store starts an access next cycle
// ACCESS | request held on the bus until ready or the wait counter expires
module mem_stage
    import mem_stage_pkg::*;
#(
    parameter int unsigned TIMEOUT = DEFAULT_TIMEOUT
) (
    input  logic                  clk,
    input  logic                  reset,

    input  logic [XLEN-1:0]       alu_result_EX_MEM,
    input  logic [XLEN-1:0]       read_data2_EX_MEM,
    input  logic [XLEN-1:0]       add_alu_out_EX_MEM,
    input  logic                  branch_EX_MEM,
    input  logic                  z_flag_EX_MEM,
    input  logic                  memread_EX_MEM,
    input  logic                  memwrite_EX_MEM,
    input  logic                  memtoreg_EX_MEM,
    input  logic                  regwrite_EX_MEM,
    input  logic [REG_ADDR_W-1:0] rd_EX_MEM,

    mem_stage_if.master           dmem,

    output logic                  pcsrc,
    output logic [XLEN-1:0]       branch_target,
    output logic                  stall_mem,
    output logic                  misalign_err,
    output logic                  bus_err,

    output logic [XLEN-1:0]       read_data_MEM_WB,
    output logic [XLEN-1:0]       alu_result_MEM_WB,
    output logic [REG_ADDR_W-1:0] rd_MEM_WB,
    output logic                  regwrite_MEM_WB,
    output logic                  memtoreg_MEM_WB
);

    localparam logic [WAIT_CNT_W-1:0] WAIT_TC = WAIT_CNT_W'(TIMEOUT - 1);

    state_e                state_q, state_d;
    logic [WAIT_CNT_W-1:0] wait_cnt_q;
    logic [XLEN-1:0]       addr_q;
    logic [XLEN-1:0]       wdata_q;
    logic                  we_q;
    logic                  misalign_err_q;

    logic                  mem_op;
    logic                  misaligned;
    logic                  wait_tc;
    logic                  wb_bubble;
    mem_wb_t               wb_d;
    mem_wb_t               wb_q;

    assign pcsrc         = branch_EX_MEM & z_flag_EX_MEM;
    assign branch_target = add_alu_out_EX_MEM;

    assign mem_op     = memread_EX_MEM | memwrite_EX_MEM;
    assign misaligned = mem_op & (alu_result_EX_MEM[1:0] != 2'b00);
    assign wait_tc    = (wait_cnt_q == WAIT_TC);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:   if (mem_op && !misaligned)       state_d = ACCESS;
            ACCESS: if (dmem.dmem_ready || wait_tc) state_d = IDLE;
        endcase
    end

    // In ACCESS the EX/MEM inputs are frozen by the stall, so rd and the
    // control bits still belong to the instruction being completed.
    always_comb begin
        dmem.dmem_req   = 1'b0;
        dmem.dmem_we    = 1'b0;
        dmem.dmem_addr  = '0;
        dmem.dmem_wdata = '0;
        stall_mem       = 1'b0;
        bus_err         = 1'b0;
        wb_bubble       = 1'b0;
        wb_d.read_data  = '0;
        wb_d.alu_result = alu_result_EX_MEM;
        wb_d.rd         = rd_EX_MEM;
        wb_d.regwrite   = regwrite_EX_MEM;
        wb_d.memtoreg   = memtoreg_EX_MEM;
        case (state_q)
            IDLE: begin
                stall_mem = mem_op & ~misaligned;
                wb_bubble = mem_op;
            end
            ACCESS: begin
                dmem.dmem_req   = 1'b1;
                dmem.dmem_we    = we_q;
                dmem.dmem_addr  = addr_q;
                dmem.dmem_wdata = wdata_q;
                stall_mem       = ~dmem.dmem_ready & ~wait_tc;
                bus_err         = ~dmem.dmem_ready & wait_tc;
                wb_bubble       = ~dmem.dmem_ready;
                wb_d.alu_result = addr_q;
                wb_d.read_data  = we_q ? '0 : dmem.dmem_rdata;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wait_cnt_q     <= '0;
            addr_q         <= '0;
            wdata_q        <= '0;
            we_q           <= 1'b0;
            misalign_err_q <= 1'b0;
        end else begin
            misalign_err_q <= (state_q == IDLE) & misaligned;
            if (state_q == IDLE) begin
                wait_cnt_q <= '0;
                if (mem_op && !misaligned) begin
                    addr_q  <= alu_result_EX_MEM;
                    wdata_q <= read_data2_EX_MEM;
                    we_q    <= memwrite_EX_MEM;
                end
            end else if (!dmem.dmem_ready && !wait_tc) begin
                wait_cnt_q <= wait_cnt_q + 1'b1;
            end
        end
    end

    assign misalign_err = misalign_err_q;

    mem_wb_reg u_mem_wb_reg (
        .clk    (clk),
        .reset  (reset),
        .bubble (wb_bubble),
        .row_d  (wb_d),
        .row_q  (wb_q)
    );

    assign read_data_MEM_WB  = wb_q.read_data;
    assign alu_result_MEM_WB = wb_q.alu_result;
    assign rd_MEM_WB         = wb_q.rd;
    assign regwrite_MEM_WB   = wb_q.regwrite;
    assign memtoreg_MEM_WB   = wb_q.memtoreg;

endmodule

// File: tb/tb_mem_stage.sv
// Bench for mem_stage: directed scenarios plus random instruction mix against
// a transaction-level model with its own copy of data memory.
module tb_mem_stage;

    localparam int T = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] alu_result_EX_MEM, read_data2_EX_MEM, add_alu_out_EX_MEM;
    logic        branch_EX_MEM, z_flag_EX_MEM, memread_EX_MEM, memwrite_EX_MEM;
    logic        memtoreg_EX_MEM, regwrite_EX_MEM;
    logic [4:0]  rd_EX_MEM;
    logic        pcsrc, stall_mem, misalign_err, bus_err;
    logic [31:0] branch_target, read_data_MEM_WB, alu_result_MEM_WB;
    logic [4:0]  rd_MEM_WB;
    logic        regwrite_MEM_WB, memtoreg_MEM_WB;

    mem_stage_if dmem();

    mem_stage #(.TIMEOUT(T)) dut (
        .clk                (clk),
        .reset              (reset),
        .alu_result_EX_MEM  (alu_result_EX_MEM),
        .read_data2_EX_MEM  (read_data2_EX_MEM),
        .add_alu_out_EX_MEM (add_alu_out_EX_MEM),
        .branch_EX_MEM      (branch_EX_MEM),
        .z_flag_EX_MEM      (z_flag_EX_MEM),
        .memread_EX_MEM     (memread_EX_MEM),
        .memwrite_EX_MEM    (memwrite_EX_MEM),
        .memtoreg_EX_MEM    (memtoreg_EX_MEM),
        .regwrite_EX_MEM    (regwrite_EX_MEM),
        .rd_EX_MEM          (rd_EX_MEM),
        .dmem               (dmem.master),
        .pcsrc              (pcsrc),
        .branch_target      (branch_target),
        .stall_mem          (stall_mem),
        .misalign_err       (misalign_err),
        .bus_err            (bus_err),
        .read_data_MEM_WB   (read_data_MEM_WB),
        .alu_result_MEM_WB  (alu_result_MEM_WB),
        .rd_MEM_WB          (rd_MEM_WB),
        .regwrite_MEM_WB    (regwrite_MEM_WB),
        .memtoreg_MEM_WB    (memtoreg_MEM_WB)
    );

    always #5 clk = ~clk;

    int          total = 0;
    int          bad   = 0;
    logic [31:0] bus_mem [64];
    logic [31:0] ref_mem [64];
    logic        exp_mis = 1'b0;

    task automatic chk1(input string tag, input logic obs, input logic exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic set_in(input logic mr, input logic mw, input logic rw, input logic mt,
                          input logic br, input logic z, input logic [31:0] alu,
                          input logic [31:0] d2, input logic [31:0] tgt, input logic [4:0] rd);
        memread_EX_MEM     = mr;
        memwrite_EX_MEM    = mw;
        regwrite_EX_MEM    = rw;
        memtoreg_EX_MEM    = mt;
        branch_EX_MEM      = br;
        z_flag_EX_MEM      = z;
        alu_result_EX_MEM  = alu;
        read_data2_EX_MEM  = d2;
        add_alu_out_EX_MEM = tgt;
        rd_EX_MEM          = rd;
    endtask

    // Clock edge, then compare the MEM/WB row (bubble means no writeback).
    task automatic edge_row(input string tag, input logic bub, input logic [31:0] rdat,
                            input logic [31:0] alu, input logic [4:0] rd,
                            input logic rw, input logic mt);
        @(posedge clk); #1;
        chk1({tag, "/regwrite"}, regwrite_MEM_WB, bub ? 1'b0 : rw);
        chk1({tag, "/memtoreg"}, memtoreg_MEM_WB, bub ? 1'b0 : mt);
        chk32({tag, "/rd"}, {27'b0, rd_MEM_WB}, bub ? 32'h0 : {27'b0, rd});
        if (!bub) begin
            chk32({tag, "/alu_result"}, alu_result_MEM_WB, alu);
            chk32({tag, "/read_data"}, read_data_MEM_WB, rdat);
        end
        chk1({tag, "/misalign_err"}, misalign_err, exp_mis);
    endtask

    task automatic run_alu(input logic [31:0] alu, input logic [4:0] rd, input logic rw,
                           input logic mt, input logic br, input logic z, input logic [31:0] tgt);
        set_in(1'b0, 1'b0, rw, mt, br, z, alu, $urandom, tgt, rd);
        dmem.dmem_ready = 1'($urandom);
        dmem.dmem_rdata = $urandom;
        #2;
        chk1("alu/pcsrc", pcsrc, br & z);
        chk32("alu/branch_target", branch_target, tgt);
        chk1("alu/stall", stall_mem, 1'b0);
        chk1("alu/req", dmem.dmem_req, 1'b0);
        chk1("alu/bus_err", bus_err, 1'b0);
        exp_mis = 1'b0;
        edge_row("alu", 1'b0, 32'h0, alu, rd, rw, mt);
    endtask

    task automatic run_misaligned(input logic wr, input logic [31:0] addr, input logic [4:0] rd);
        set_in(~wr, wr, 1'b1, ~wr, 1'b0, 1'b0, addr, $urandom, 32'h0, rd);
        dmem.dmem_ready = 1'b0;
        #2;
        chk1("mis/req", dmem.dmem_req, 1'b0);
        chk1("mis/stall", stall_mem, 1'b0);
        exp_mis = 1'b1;
        edge_row("mis", 1'b1, 32'h0, 32'h0, rd, 1'b1, 1'b0);
        exp_mis = 1'b0;
    endtask

    // Load/store with ready arriving after lat wait cycles (lat >= T-1 times out unless lat == T-1).
    task automatic run_mem(input logic wr, input logic [31:0] addr, input logic [31:0] data,
                           input logic [4:0] rd, input logic rw, input logic mt, input int lat);
        int   n_acc;
        logic tout, rdy, last;
        n_acc = ((lat < T - 1) ? lat : T - 1) + 1;
        tout  = (lat > T - 1);
        set_in(~wr, wr, rw, mt, 1'b0, 1'b0, addr, data, 32'h0, rd);
        dmem.dmem_ready = 1'($urandom);
        dmem.dmem_rdata = $urandom;
        #2;
        chk1("mem_idle/stall", stall_mem, 1'b1);
        chk1("mem_idle/req", dmem.dmem_req, 1'b0);
        chk1("mem_idle/we", dmem.dmem_we, 1'b0);
        chk32("mem_idle/addr", dmem.dmem_addr, 32'h0);
        exp_mis = 1'b0;
        edge_row("mem_idle", 1'b1, 32'h0, 32'h0, rd, rw, mt);
        for (int k = 0; k < n_acc; k++) begin
            rdy  = (k == lat);
            last = (k == n_acc - 1);
            dmem.dmem_ready = rdy;
            dmem.dmem_rdata = $urandom;
            #1;
            if (rdy) dmem.dmem_rdata = bus_mem[dmem.dmem_addr[7:2]];
            #1;
            chk1("acc/req", dmem.dmem_req, 1'b1);
            chk1("acc/we", dmem.dmem_we, wr);
            chk32("acc/addr", dmem.dmem_addr, addr);
            chk32("acc/wdata", dmem.dmem_wdata, data);
            chk1("acc/stall", stall_mem, !rdy && !(tout && last));
            chk1("acc/bus_err", bus_err, tout && last);
            if (rdy && dmem.dmem_we) bus_mem[dmem.dmem_addr[7:2]] = dmem.dmem_wdata;
            edge_row("acc", !(last && !tout), wr ? 32'h0 : ref_mem[addr[7:2]], addr, rd, rw, mt);
        end
        if (wr && !tout) ref_mem[addr[7:2]] = data;
        dmem.dmem_ready = 1'b0;
    endtask

    initial begin
        int          kind;
        logic [31:0] a;
        for (int i = 0; i < 64; i++) begin
            bus_mem[i] = $urandom;
            ref_mem[i] = bus_mem[i];
        end
        bus_mem[4] = 32'hDEAD_BEEF;
        ref_mem[4] = 32'hDEAD_BEEF;
        dmem.dmem_ready = 1'b0;
        dmem.dmem_rdata = 32'h0;
        set_in(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 5'd0);
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk1("rst/req", dmem.dmem_req, 1'b0);
        chk1("rst/stall", stall_mem, 1'b0);
        chk1("rst/misalign_err", misalign_err, 1'b0);
        chk1("rst/bus_err", bus_err, 1'b0);
        chk1("rst/regwrite", regwrite_MEM_WB, 1'b0);
        chk32("rst/read_data", read_data_MEM_WB, 32'h0);
        reset = 1'b0;

        run_alu(32'd7, 5'd5, 1'b1, 1'b0, 1'b1, 1'b1, 32'h100);
        run_alu(32'd9, 5'd6, 1'b1, 1'b1, 1'b1, 1'b0, 32'h200);
        run_mem(1'b0, 32'h10, 32'h0, 5'd3, 1'b1, 1'b1, 0);
        run_mem(1'b1, 32'h20, 32'h1234_5678, 5'd0, 1'b0, 1'b0, 3);
        run_mem(1'b0, 32'h20, 32'h0, 5'd8, 1'b1, 1'b1, 1);
        run_misaligned(1'b0, 32'h13, 5'd4);
        run_alu(32'd1, 5'd2, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
        run_mem(1'b0, 32'h30, 32'h0, 5'd9, 1'b1, 1'b1, 100);
        run_alu(32'd3, 5'd1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
        run_mem(1'b0, 32'h30, 32'h0, 5'd9, 1'b1, 1'b1, T - 1);

        for (int i = 0; i < 40; i++) begin
            kind = int'($urandom_range(0, 3));
            a    = {24'h0, 6'($urandom_range(0, 63)), 2'b00};
            case (kind)
                0: run_alu($urandom, 5'($urandom), 1'($urandom), 1'($urandom),
                           1'($urandom), 1'($urandom), $urandom);
                1: run_mem(1'b0, a, $urandom, 5'($urandom), 1'($urandom), 1'($urandom),
                           int'($urandom_range(0, 5)));
                2: run_mem(1'b1, a, $urandom, 5'($urandom), 1'($urandom), 1'($urandom),
                           int'($urandom_range(0, 5)));
                default: run_misaligned(1'($urandom), a | {30'h0, 2'($urandom_range(1, 3))},
                                        5'($urandom));
            endcase
        end

        run_alu(32'hABCD, 5'd7, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
        set_in(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h40, 32'h0, 32'h0, 5'd10);
        dmem.dmem_ready = 1'b0;
        repeat (3) @(posedge clk);
        #3;
        chk1("midrst/req_before", dmem.dmem_req, 1'b1);
        reset = 1'b1;
        #1;
        chk1("midrst/req", dmem.dmem_req, 1'b0);
        chk1("midrst/bus_err", bus_err, 1'b0);
        chk1("midrst/misalign_err", misalign_err, 1'b0);
        chk1("midrst/regwrite", regwrite_MEM_WB, 1'b0);
        chk32("midrst/alu_result", alu_result_MEM_WB, 32'h0);
        chk32("midrst/rd", {27'b0, rd_MEM_WB}, 32'h0);
        set_in(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 5'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        run_mem(1'b0, 32'h40, 32'h0, 5'd10, 1'b1, 1'b1, 2);
        run_alu(32'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
